// File: rtl/seq_mux_arb_rr.sv
// Registered N-to-1 stream mux: picks one valid/ready input channel per cycle by
// round-robin or fixed priority and forwards it through a single output register.
module seq_mux_arb_rr #(
    parameter int nbits = 8,
    parameter int nreqs = 8,
    parameter int p_rr  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [nreqs-1:0]         in_val,
    output logic [nreqs-1:0]         in_rdy,
    input  logic [nbits*nreqs-1:0]   in_msg,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [nbits-1:0]         out_msg,
    output logic [$clog2(nreqs)-1:0] out_sel
);

    localparam int sel_w = $clog2(nreqs);
    localparam int unsigned nreq_u = nreqs;
    localparam logic [sel_w:0] n_w = (sel_w + 1)'(nreqs);
    localparam logic [sel_w-1:0] last_idx = sel_w'(nreqs - 1);

    logic [sel_w-1:0] ptr;
    logic [sel_w-1:0] gidx;
    logic [sel_w-1:0] ptr_nxt;
    logic [nreqs-1:0] grant;
    logic             found;
    logic             free;
    logic             xfer;
    logic [nbits-1:0] gmsg;

    // Search starts at ptr (round-robin) or 0 (fixed priority) and wraps once.
    always_comb begin : arbitrate
        logic [sel_w-1:0] base;
        logic [sel_w:0]   sum;
        logic [sel_w-1:0] idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        base  = (p_rr != 0) ? ptr : '0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < nreq_u; k++) begin
            sum = {1'b0, base} + (sel_w + 1)'(k);
            if (sum >= n_w) begin
                sum = sum - n_w;
            end
            idx = sel_w'(sum);
            if (!found && in_val[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_comb begin
        gmsg    = in_msg[32'(gidx) * nbits +: nbits];
        ptr_nxt = (gidx == last_idx) ? '0 : gidx + 1'b1;
        free    = !out_val || out_rdy;
        in_rdy  = (free && !reset) ? grant : '0;
        xfer    = |(in_val & in_rdy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_sel <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            out_val <= 1'b1;
            out_msg <= gmsg;
            out_sel <= gidx;
            if (p_rr != 0) begin
                ptr <= ptr_nxt;
            end
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_mux_arb_rr.sv
// Self-checking bench for seq_mux_arb_rr: a round-robin and a fixed-priority
// instance, with a reference model that queues expected output messages.
module tb_seq_mux_arb_rr;

    logic        clk;
    logic        reset;
    logic [7:0]  rv;
    logic [7:0]  rr_rdy;
    logic [7:0]  fv;
    logic [7:0]  fp_rdy;
    logic [63:0] in_msg;
    logic        out_rdy;
    logic        rr_oval;
    logic        fp_oval;
    logic [7:0]  rr_omsg;
    logic [7:0]  fp_omsg;
    logic [2:0]  rr_osel;
    logic [2:0]  fp_osel;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] msg;
    } exp_t;

    exp_t sbq[$];
    logic m_val;
    int   m_ptr;

    seq_mux_arb_rr #(.nbits(8), .nreqs(8), .p_rr(1)) dut_rr (
        .clk(clk), .reset(reset), .in_val(rv), .in_rdy(rr_rdy), .in_msg(in_msg),
        .out_val(rr_oval), .out_rdy(out_rdy), .out_msg(rr_omsg), .out_sel(rr_osel)
    );

    seq_mux_arb_rr #(.nbits(8), .nreqs(8), .p_rr(0)) dut_fp (
        .clk(clk), .reset(reset), .in_val(fv), .in_rdy(fp_rdy), .in_msg(in_msg),
        .out_val(fp_oval), .out_rdy(out_rdy), .out_msg(fp_omsg), .out_sel(fp_osel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [7:0] v, input int p);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (p + k) % 8;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void exp_out(output logic v, output logic [7:0] m, output logic [2:0] s);
        v = (sbq.size() != 0);
        m = v ? sbq[0].msg : 8'h00;
        s = v ? sbq[0].sel : 3'd0;
    endfunction

    // Drive round-robin inputs and advance the model for the coming edge.
    task automatic drive(input logic [7:0] v, input logic ordy, output logic [7:0] exp_rdy);
        logic free;
        int   g;
        rv      = v;
        out_rdy = ordy;
        #1;
        exp_rdy = '0;
        free    = !m_val || ordy;
        g       = rr_pick(v, m_ptr);
        if (m_val && ordy) begin
            sbq.delete(0);
            m_val = 1'b0;
        end
        if (free && g >= 0) begin
            exp_t e;
            e.sel = 3'(g);
            e.msg = in_msg[g*8 +: 8];
            sbq.push_back(e);
            m_val      = 1'b1;
            m_ptr      = (g + 1) % 8;
            exp_rdy[g] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] er;
        logic       ev;
        logic [7:0] em;
        logic [2:0] es;
        rv = '0; fv = '0; out_rdy = 1'b0; in_msg = '0; reset = 1'b1;
        tick();
        rv = 8'hFF; fv = 8'hFF;
        #1;
        n_cmp++;
        if (rr_oval !== 1'b0 || rr_omsg !== 8'h00 || rr_osel !== 3'd0) begin
            n_err++;
            $display("FAIL reset_init: got val=%b msg=%h sel=%0d want 0/00/0", rr_oval, rr_omsg, rr_osel);
        end
        n_cmp++;
        if (rr_rdy !== 8'h00 || fp_rdy !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rdy: got rr=%h fp=%h want 00/00", rr_rdy, fp_rdy);
        end
        rv = '0; fv = '0;
        #1;
        reset = 1'b0;
        sbq.delete(); m_val = 1'b0; m_ptr = 0;
        tick();
        in_msg[7:0] = 8'hA5;
        drive(8'h01, 1'b0, er);
        n_cmp++;
        if (rr_rdy !== er) begin
            n_err++;
            $display("FAIL load_a5_rdy: got %h want %h", rr_rdy, er);
        end
        tick();
        rv = '0;
        exp_out(ev, em, es);
        n_cmp++;
        if (rr_oval !== ev || rr_omsg !== em || rr_osel !== es || rr_omsg !== 8'hA5) begin
            n_err++;
            $display("FAIL load_a5_out: got %b/%h/%0d want %b/%h/%0d", rr_oval, rr_omsg, rr_osel, ev, em, es);
        end
        #2;
        reset = 1'b1;
        rv = 8'hFF;
        #1;
        n_cmp++;
        if (rr_oval !== 1'b0 || rr_omsg !== 8'h00 || rr_osel !== 3'd0) begin
            n_err++;
            $display("FAIL reset_async: got val=%b msg=%h sel=%0d want 0/00/0", rr_oval, rr_omsg, rr_osel);
        end
        n_cmp++;
        if (rr_rdy !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async_rdy: got %h want 00", rr_rdy);
        end
        rv = '0;
        #1;
        reset = 1'b0;
        sbq.delete(); m_val = 1'b0; m_ptr = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [7:0] er;
        logic [7:0] one;
        logic       ev;
        logic [7:0] em;
        logic [2:0] es;
        one = 8'h01;
        for (int i = 0; i < 8; i++) in_msg[i*8 +: 8] = 8'(8'h10 + i);
        for (int c = 0; c < 10; c++) begin
            exp_out(ev, em, es);
            n_cmp++;
            if (rr_oval !== ev || (ev && (rr_omsg !== em || rr_osel !== es))) begin
                n_err++;
                $display("FAIL fair_out[%0d]: got %b/%h/%0d want %b/%h/%0d", c, rr_oval, rr_omsg, rr_osel, ev, em, es);
            end
            drive(8'hFF, 1'b1, er);
            n_cmp++;
            if (rr_rdy !== er || rr_rdy !== (one << (c % 8))) begin
                n_err++;
                $display("FAIL fair_rdy[%0d]: got %h want %h", c, rr_rdy, one << (c % 8));
            end
            tick();
        end
        n_cmp++;
        if (rr_oval !== 1'b1 || rr_osel !== 3'd1 || rr_omsg !== 8'h11) begin
            n_err++;
            $display("FAIL fair_last: got %b/%h/%0d want 1/11/1", rr_oval, rr_omsg, rr_osel);
        end
        drive(8'h00, 1'b1, er);
        tick();
        n_cmp++;
        if (rr_oval !== 1'b0) begin
            n_err++;
            $display("FAIL fair_drain: got val=%b want 0", rr_oval);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] er;
        logic       ev;
        logic [7:0] em;
        logic [2:0] es;
        in_msg[3*8 +: 8] = 8'h33;
        drive(8'h08, 1'b0, er);
        n_cmp++;
        if (rr_rdy !== er || rr_rdy !== 8'h08) begin
            n_err++;
            $display("FAIL bp_first_rdy: got %h want 08", rr_rdy);
        end
        tick();
        for (int c = 1; c < 4; c++) begin
            exp_out(ev, em, es);
            n_cmp++;
            if (rr_oval !== ev || rr_omsg !== em || rr_osel !== es || rr_omsg !== 8'h33) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got %b/%h/%0d want %b/%h/%0d", c, rr_oval, rr_omsg, rr_osel, ev, em, es);
            end
            drive(8'h08, 1'b0, er);
            n_cmp++;
            if (rr_rdy !== er || rr_rdy !== 8'h00) begin
                n_err++;
                $display("FAIL bp_rdy[%0d]: got %h want 00", c, rr_rdy);
            end
            tick();
        end
        in_msg[3*8 +: 8] = 8'h34;
        drive(8'h08, 1'b1, er);
        n_cmp++;
        if (rr_rdy !== er || rr_rdy !== 8'h08) begin
            n_err++;
            $display("FAIL bp_release_rdy: got %h want 08", rr_rdy);
        end
        tick();
        exp_out(ev, em, es);
        n_cmp++;
        if (rr_oval !== ev || rr_omsg !== em || rr_osel !== es || rr_omsg !== 8'h34) begin
            n_err++;
            $display("FAIL bp_release_out: got %b/%h/%0d want %b/%h/%0d", rr_oval, rr_omsg, rr_osel, ev, em, es);
        end
        drive(8'h00, 1'b1, er);
        tick();
    endtask

    task automatic test_sparse_rr();
        logic [7:0] er;
        logic [7:0] want_rdy [4];
        logic [7:0] vals     [4];
        logic       ev;
        logic [7:0] em;
        logic [2:0] es;
        // ch4 moves ptr to 5; then {2,6} grants 6, wraps to 2; {2,3} then grants 3 (ptr=3).
        vals[0] = 8'h10; want_rdy[0] = 8'h10;
        vals[1] = 8'h44; want_rdy[1] = 8'h40;
        vals[2] = 8'h44; want_rdy[2] = 8'h04;
        vals[3] = 8'h0C; want_rdy[3] = 8'h08;
        for (int c = 0; c < 4; c++) begin
            drive(vals[c], 1'b1, er);
            n_cmp++;
            if (rr_rdy !== er || rr_rdy !== want_rdy[c]) begin
                n_err++;
                $display("FAIL sparse_rdy[%0d]: got %h want %h", c, rr_rdy, want_rdy[c]);
            end
            tick();
            exp_out(ev, em, es);
            n_cmp++;
            if (rr_oval !== ev || rr_omsg !== em || rr_osel !== es) begin
                n_err++;
                $display("FAIL sparse_out[%0d]: got %b/%h/%0d want %b/%h/%0d", c, rr_oval, rr_omsg, rr_osel, ev, em, es);
            end
        end
        drive(8'h00, 1'b1, er);
        tick();
    endtask

    task automatic test_fixed_priority();
        fv = 8'h12;
        out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (fp_rdy !== 8'h02) begin
                n_err++;
                $display("FAIL fp_rdy[%0d]: got %h want 02", c, fp_rdy);
            end
            tick();
            n_cmp++;
            if (fp_oval !== 1'b1 || fp_osel !== 3'd1 || fp_omsg !== 8'h11) begin
                n_err++;
                $display("FAIL fp_out[%0d]: got %b/%h/%0d want 1/11/1", c, fp_oval, fp_omsg, fp_osel);
            end
        end
        fv = 8'h10;
        #1;
        n_cmp++;
        if (fp_rdy !== 8'h10) begin
            n_err++;
            $display("FAIL fp_drop_rdy: got %h want 10", fp_rdy);
        end
        tick();
        n_cmp++;
        if (fp_oval !== 1'b1 || fp_osel !== 3'd4 || fp_omsg !== 8'h14) begin
            n_err++;
            $display("FAIL fp_drop_out: got %b/%h/%0d want 1/14/4", fp_oval, fp_omsg, fp_osel);
        end
        fv = 8'h00;
        tick();
    endtask

    task automatic test_idle_drain();
        logic [7:0] er;
        logic       ev;
        logic [7:0] em;
        logic [2:0] es;
        in_msg[7*8 +: 8] = 8'hFE;
        drive(8'h80, 1'b1, er);
        n_cmp++;
        if (rr_rdy !== er || rr_rdy !== 8'h80) begin
            n_err++;
            $display("FAIL idle_rdy: got %h want 80", rr_rdy);
        end
        tick();
        exp_out(ev, em, es);
        n_cmp++;
        if (rr_oval !== ev || rr_omsg !== em || rr_osel !== es || rr_oval !== 1'b1) begin
            n_err++;
            $display("FAIL idle_one: got %b/%h/%0d want %b/%h/%0d", rr_oval, rr_omsg, rr_osel, ev, em, es);
        end
        for (int c = 0; c < 3; c++) begin
            drive(8'h00, 1'b1, er);
            tick();
            n_cmp++;
            if (rr_oval !== 1'b0 || rr_osel !== 3'd7 || rr_omsg !== 8'hFE) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got %b/%h/%0d want 0/fe/7", c, rr_oval, rr_omsg, rr_osel);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_val = 1'b0;
        m_ptr = 0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse_rr();
        test_fixed_priority();
        test_idle_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mux_arb_rr.md
Name: seq_mux_arb_rr

Overview:
- Parametrised, registered successor to the 1-bit 8-to-1 combinational mux.
- Selects one of nreqs nbits-wide valid/ready input streams and forwards it through a single output register.
- Selection is by internal round-robin or fixed-priority arbitration rather than an external sel.
- Sits in front of shared resources (response networks, shared memory ports) where several producers feed one consumer.

Parameters:
- nbits, 8, width of each message.
- nreqs, 8, number of input channels (legal range 2..32).
- p_rr, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  nreqs  per-channel valid; bit i belongs to channel i.
- in_rdy  output  nreqs  per-channel ready; bit i belongs to channel i.
- in_msg  input  nbits*nreqs  flattened messages; channel i occupies bits [i*nbits +: nbits].
- out_val  output  1  output register holds a valid message.
- out_rdy  input  1  consumer accepts the message.
- out_msg  output  nbits  registered selected message.
- out_sel  output  $clog2(nreqs)  registered index of the channel that supplied out_msg.

Behaviour:
- Reset (async, takes effect immediately on assertion): out_val=0, out_msg=0, out_sel=0, round-robin pointer ptr=0. While reset is high, in_rdy=0.
- Output register is a single entry. It is free when !out_val || out_rdy, so a pipelined transfer is allowed on the same cycle the consumer drains it.
- Grant is combinational and one-hot or zero:
  - p_rr=1: the first channel with in_val set, searching i = ptr, ptr+1, ... nreqs-1, 0, ... ptr-1 (wrap-around).
  - p_rr=0: the lowest-index channel with in_val set; ptr is unused and stays 0.
- in_rdy[i] = grant[i] && free.
- in_rdy must not depend on in_msg. It depends on in_val only through grant.
- At most one in_rdy bit is high in any cycle.
- Input transfer on channel g: in_val[g] && in_rdy[g]. At the next edge:
  - out_val=1
  - out_msg = in_msg channel g
  - out_sel = g
  - if p_rr=1, ptr = (g+1) mod nreqs (wrap from nreqs-1 to 0)
- Output transfer without an input transfer: out_val=0 next cycle. out_msg and out_sel hold their values.
- No transfer: all state holds. ptr advances only on an accepted transfer, never on grant alone.
- Latency: exactly one cycle from input acceptance to out_val. Sustained throughput is one message per cycle when out_rdy=1.
- out_val stays high and out_msg/out_sel stay stable while out_rdy=0 (no drop, no overwrite).
- No channel sees in_rdy while the register is full and out_rdy=0.
- Fairness (p_rr=1): with all channels continuously valid and out_rdy=1, grants cycle 0,1,...,nreqs-1,0,... Each channel waits at most nreqs-1 accepted transfers.
- A channel that drops in_val is simply skipped. A channel becoming valid mid-cycle takes part in the same cycle's arbitration (combinational).
- Reset mid-operation discards any held message (out_val=0) and returns ptr to 0. The first grant after reset is the lowest valid index at or above 0.

Test Plan:
- Reset with out_val=1 holding 0xA5 -> out_val=0, out_msg=0, out_sel=0 immediately, before the next edge; in_rdy=0 during reset.
- nbits=8, nreqs=8, p_rr=1: all in_val=0xFF, in_msg channel i = 0x10+i, out_rdy=1 for 10 cycles -> out_sel sequence 0,1,2,3,4,5,6,7,0,1; out_msg 0x10..0x17,0x10,0x11; one in_rdy bit high per cycle.
- Backpressure: channel 3 valid with 0x33, out_rdy=0 for 4 cycles -> out_val=1, out_msg=0x33 held; in_rdy=0 for all channels after the first transfer; out_rdy=1 -> next message accepted on the same cycle.
- Sparse round-robin: ptr=5, only channels 2 and 6 valid -> grant 6 and ptr becomes 7; next cycle grant wraps to 2 and ptr becomes 3.
- p_rr=0: channels 1 and 4 continuously valid, out_rdy=1 -> channel 1 granted every cycle; channel 4 is granted only after in_val[1] drops.
- Idle/drain: single transfer from channel 7 (0xFE), then no valid inputs with out_rdy=1 -> out_val high for exactly one cycle, then 0; out_sel=7 held.
